// File: rtl/fifo_arb_pkg.sv
// Shared types and width helper for the FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    ARB  = 1'b0,
    XFER = 1'b1
  } arb_state_t;

  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set request strictly after ptr, wrapping modulo NREQ.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDXW = idx_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] ptr,
  output logic            any,
  output logic [IDXW-1:0] idx
);

  logic [NREQ-1:0] rot;
  int              sel;

  // Rotate so the slot after ptr lands at bit 0, priority-encode, then undo the rotation.
  always_comb begin
    rot = '0;
    sel = 0;
    for (int i = 0; i < NREQ; i++) begin
      rot[i] = req[(i + int'(ptr) + 1) % NREQ];
    end
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (rot[i]) sel = i;
    end
    any = |req;
    idx = IDXW'((sel + int'(ptr) + 1) % NREQ);
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Packet-locked round-robin arbiter sharing one async-FIFO write port among NREQ requesters.
//   state | meaning
//   ARB   | idle / choosing the next owner; no writes this cycle
//   XFER  | grant_id owns the write port until its last beat is written
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int DWIDTH = 8,
  parameter int IDXW   = idx_width(NREQ)
) (
  input  logic                   wclk,
  input  logic                   wrst,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*DWIDTH-1:0] req_data,
  input  logic [NREQ-1:0]        req_last,
  output logic [NREQ-1:0]        req_ready,
  input  logic                   wfull,
  output logic                   winc,
  output logic [DWIDTH-1:0]      wdata,
  output logic [IDXW-1:0]        grant_id,
  output logic                   busy,
  output logic                   pkt_done
);

  arb_state_t      state_q, state_d;
  logic [IDXW-1:0] rr_ptr;
  logic            pick_any;
  logic [IDXW-1:0] pick_idx;
  logic            xfer_last;

  rr_pick #(.NREQ(NREQ), .IDXW(IDXW)) u_pick (
    .req (req_valid),
    .ptr (rr_ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      state_q  <= ARB;
      grant_id <= '0;
      rr_ptr   <= IDXW'(NREQ - 1);
      pkt_done <= 1'b0;
    end else begin
      state_q  <= state_d;
      pkt_done <= xfer_last;
      if (state_q == ARB && pick_any) begin
        grant_id <= pick_idx;
        rr_ptr   <= pick_idx;
      end else if (xfer_last) begin
        grant_id <= '0;
      end
    end
  end

  // wfull gates the strobe combinationally; the FIFO's registered flag makes this safe.
  always_comb begin
    state_d   = state_q;
    winc      = 1'b0;
    req_ready = '0;
    busy      = 1'b0;
    xfer_last = 1'b0;
    wdata     = req_data[int'(grant_id)*DWIDTH +: DWIDTH];
    case (state_q)
      ARB: begin
        if (pick_any) state_d = XFER;
      end
      XFER: begin
        busy                = 1'b1;
        req_ready[grant_id] = ~wfull;
        winc                = req_valid[grant_id] & ~wfull;
        xfer_last           = winc & req_last[grant_id];
        if (xfer_last) state_d = ARB;
      end
      default: state_d = ARB;
    endcase
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter (NREQ=4 main instance, NREQ=3 instance for wrap-around).
module tb_fifo_wr_arbiter;

  logic        wclk;
  logic        wrst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic        wfull;
  logic        winc;
  logic [7:0]  wdata;
  logic [1:0]  grant_id;
  logic        busy;
  logic        pkt_done;

  logic [2:0]  v3, l3, rdy3;
  logic [23:0] d3;
  logic        winc3, busy3, done3;
  logic [7:0]  wdata3;
  logic [1:0]  gid3;

  int checks = 0;
  int errors = 0;
  int wr_count = 0;

  fifo_wr_arbiter #(.NREQ(4), .DWIDTH(8)) dut (
    .wclk(wclk), .wrst(wrst), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .wfull(wfull), .winc(winc),
    .wdata(wdata), .grant_id(grant_id), .busy(busy), .pkt_done(pkt_done)
  );

  fifo_wr_arbiter #(.NREQ(3), .DWIDTH(8)) dut3 (
    .wclk(wclk), .wrst(wrst), .req_valid(v3), .req_data(d3),
    .req_last(l3), .req_ready(rdy3), .wfull(1'b0), .winc(winc3),
    .wdata(wdata3), .grant_id(gid3), .busy(busy3), .pkt_done(done3)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  always @(negedge wclk) if (winc === 1'b1) wr_count++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge wclk);
    #1;
  endtask

  initial begin
    wrst = 1'b1; req_valid = '0; req_data = '0; req_last = '0; wfull = 1'b0;
    v3 = '0; l3 = '0; d3 = '0;
    #12;
    chk("rst_grant", grant_id, 0);
    chk("rst_busy", busy, 0);
    chk("rst_winc", winc, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_done", pkt_done, 0);
    tick();
    wrst = 1'b0;

    // Requester 2, three-beat packet
    req_valid = 4'b0100; req_data[23:16] = 8'hA1; #1;
    chk("t1_arb_winc", winc, 0);
    tick();
    chk("t1_grant", grant_id, 2);
    chk("t1_busy", busy, 1);
    chk("t1_ready", req_ready, 4'b0100);
    chk("t1_winc1", winc, 1);
    chk("t1_wdata1", wdata, 8'hA1);
    tick();
    req_data[23:16] = 8'hA2; #1;
    chk("t1_winc2", winc, 1);
    chk("t1_wdata2", wdata, 8'hA2);
    chk("t1_done_mid", pkt_done, 0);
    tick();
    req_data[23:16] = 8'hA3; req_last = 4'b0100; #1;
    chk("t1_winc3", winc, 1);
    chk("t1_wdata3", wdata, 8'hA3);
    tick();
    req_valid = '0; req_last = '0; #1;
    chk("t1_done", pkt_done, 1);
    chk("t1_idle_busy", busy, 0);
    chk("t1_idle_grant", grant_id, 0);
    tick();
    chk("t1_done_clr", pkt_done, 0);

    // All four requesters with single-beat packets straight out of reset
    wrst = 1'b1; #1; wrst = 1'b0;
    req_valid = 4'b1111; req_last = 4'b1111;
    req_data = {8'h13, 8'h12, 8'h11, 8'h10}; #1;
    for (int k = 0; k < 5; k++) begin
      chk("t2_arb_winc", winc, 0);
      chk("t2_arb_busy", busy, 0);
      tick();
      chk("t2_grant", grant_id, k % 4);
      chk("t2_winc", winc, 1);
      chk("t2_wdata", wdata, 8'h10 + (k % 4));
      tick();
    end
    req_valid = '0; req_last = '0; #1;
    chk("t2_done", pkt_done, 1);

    // Requester 1 stalled by wfull for 5 cycles mid-packet
    tick();
    wr_count = 0;
    req_valid = 4'b0010; req_data[15:8] = 8'h21; #1;
    tick();
    chk("t3_grant", grant_id, 1);
    chk("t3_wdata1", wdata, 8'h21);
    tick();
    req_data[15:8] = 8'h22; wfull = 1'b1; #1;
    for (int k = 0; k < 5; k++) begin
      chk("t3_full_winc", winc, 0);
      chk("t3_full_ready", req_ready, 0);
      chk("t3_full_busy", busy, 1);
      tick();
    end
    wfull = 1'b0; #1;
    chk("t3_resume_winc", winc, 1);
    chk("t3_resume_data", wdata, 8'h22);
    tick();
    req_data[15:8] = 8'h23; req_last = 4'b0010; #1;
    chk("t3_last_winc", winc, 1);
    tick();
    req_valid = '0; req_last = '0; #1;
    chk("t3_done", pkt_done, 1);
    chk("t3_writes", wr_count, 3);

    // Requester 0 goes quiet mid-packet while requester 3 waits
    tick();
    req_valid = 4'b0001; req_data[7:0] = 8'h31; #1;
    tick();
    chk("t4_grant", grant_id, 0);
    chk("t4_winc1", winc, 1);
    tick();
    req_valid = 4'b1000; req_data[31:24] = 8'h41; #1;
    for (int k = 0; k < 2; k++) begin
      chk("t4_gap_winc", winc, 0);
      chk("t4_gap_grant", grant_id, 0);
      chk("t4_gap_ready", req_ready, 4'b0001);
      tick();
    end
    req_valid = 4'b1001; req_data[7:0] = 8'h32; req_last = 4'b0001; #1;
    chk("t4_last_winc", winc, 1);
    chk("t4_last_data", wdata, 8'h32);
    tick();
    req_valid = 4'b1000; req_last = '0; #1;
    chk("t4_done", pkt_done, 1);
    chk("t4_arb_busy", busy, 0);
    tick();
    chk("t4_grant3", grant_id, 3);
    chk("t4_wdata3", wdata, 8'h41);

    // Asynchronous reset during requester 3's packet
    #2; wrst = 1'b1; #1;
    chk("t5_rst_winc", winc, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_ready", req_ready, 0);
    chk("t5_rst_grant", grant_id, 0);
    wrst = 1'b0;
    req_valid = 4'b1001; req_last = 4'b1001; req_data[7:0] = 8'h50; #1;
    tick();
    chk("t5_grant0", grant_id, 0);
    chk("t5_wdata0", wdata, 8'h50);
    tick();
    req_valid = '0; req_last = '0;

    // NREQ=3 wrap: grant 2, then requesters 0 and 1 -> 0
    v3 = 3'b100; l3 = 3'b100; d3 = {8'h62, 8'h61, 8'h60}; #1;
    tick();
    chk("t6_grant2", gid3, 2);
    chk("t6_winc2", winc3, 1);
    tick();
    v3 = 3'b011; l3 = 3'b011; #1;
    tick();
    chk("t6_wrap_grant", gid3, 0);
    chk("t6_wrap_data", wdata3, 8'h60);
    tick();
    v3 = '0; l3 = '0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Shares the single write port of the async FIFO write domain (write pointer / full-flag logic plus dual-port RAM) among NREQ requesters.
- Per-requester valid/ready interface; packet-locked round-robin arbitration.
- Drives winc/wdata into the FIFO write side and honours its registered wfull flag.
- Lives entirely in the write clock domain.

Parameters:
- NREQ, 4, number of requesters (2..16)
- DWIDTH, 8, data width per beat
- IDXW, $clog2(NREQ), width of the grant index (derived; do not override)

Ports:
- wclk  in  1  write-domain clock
- wrst  in  1  asynchronous active-high reset
- req_valid  in  NREQ  per-requester beat valid
- req_data  in  NREQ*DWIDTH  per-requester beat data; requester i occupies bits [i*DWIDTH +: DWIDTH]
- req_last  in  NREQ  marks the final beat of a packet
- req_ready  out  NREQ  beat accepted this cycle (valid & ready = transfer)
- wfull  in  1  FIFO full flag from the write-pointer block (registered there)
- winc  out  1  FIFO write strobe
- wdata  out  DWIDTH  FIFO write data
- grant_id  out  IDXW  index of the current owner; 0 when idle
- busy  out  1  high while a packet is granted
- pkt_done  out  1  one-cycle pulse when the last beat of a packet is written

Behaviour:
- Reset (wrst high, asynchronous): state=ARB, grant_id=0, rr pointer=NREQ-1 (so requester 0 has priority first), pkt_done=0. winc, req_ready and busy drop to 0 immediately, since they decode from state.
- States:
  - ARB: if any req_valid, pick the first valid requester scanning upward from rr_ptr+1 modulo NREQ. Register it into grant_id and set rr_ptr=picked. Next state is XFER. If nothing is valid, stay in ARB.
  - XFER: owner g = grant_id.
    - winc = req_valid[g] & ~wfull.
    - req_ready[g] = ~wfull; all other req_ready bits are 0.
    - wdata = req_data[g] (combinational mux).
    - On a transfer with req_last[g]=1: next state ARB and pkt_done=1 on the next cycle.
- Outputs in ARB: winc=0, req_ready=0, busy=0. busy=1 exactly in XFER.
- Latency: one ARB bubble cycle per packet. The first beat of a packet can be written in the cycle after the request is seen in ARB.
- Packet lock: the grant holds until the last beat, regardless of other requests.
  - If req_valid[g] deasserts mid-packet, hold the grant and keep winc=0.
- Full: while wfull=1, winc=0 and req_ready=0; the state does not change. wfull is sampled combinationally in the same cycle. The FIFO's registered full flag guarantees a winc in the cycle it asserts is never lost.
- Single-beat packet (valid & last on the first XFER cycle): one write, then back to ARB.
- Wrap-around: after a grant to NREQ-1, the scan starts at 0.
- A requester becoming valid in the same cycle as ARB is eligible in that cycle.
- wdata is don't-care when winc=0; it is still driven from the mux, never X after reset.
- Reset asserted mid-packet: the packet is abandoned and beats already written stay in the FIFO. After deassertion, arbitration restarts with requester 0 first.

Decomposition:
- Package fifo_arb_pkg:
  - state enum {ARB, XFER}
  - localparam function for IDXW
- Sub-module rr_pick: combinational round-robin picker.
  - Inputs: req[NREQ], ptr[IDXW].
  - Outputs: any, idx[IDXW].
  - Implemented as a rotate → priority-encode → un-rotate.
- Top level holds the FSM, the grant register, rr_ptr, the data mux and the pkt_done register.

Test Plan:
- Single requester, req 2 sends a 3-beat packet, wfull=0 → grant_id=2 one cycle after valid; winc high for 3 consecutive cycles; wdata matches beats; pkt_done pulses once; then busy=0.
- All 4 valid with continuous 1-beat packets from reset → grants in order 0,1,2,3,0; one winc every 2 cycles.
- wfull asserted for 5 cycles mid-packet from req 1 → winc=0 and req_ready=0 for exactly those 5 cycles; no beat lost or duplicated; the packet resumes on the cycle wfull drops.
- Req 0 drops req_valid for 2 cycles mid-packet while req 3 is valid → grant stays 0; req 3 is served only after req 0's last beat.
- wrst pulsed asynchronously (between wclk edges) during XFER of req 3 → winc, busy and req_ready go 0 within the same cycle; after release, req 0 and req 3 both valid → req 0 granted first.
- Wrap check, NREQ=3 build: last grant was 2, requesters 0 and 1 valid → grant 0.
